fetch: RTL and testbench
========================

# fetch

Instruction fetch unit feeding the decoder's 16-bit op stream. Issues word-aligned 32-bit reads to the instruction memory port and splits each returned word into two halfwords. Queues them with their addresses and presents them to the decoder through the `opready`/`d_ready` handshake. Supports control-flow redirects with queue flush and discard of in-flight reads.

## Interface
- `DATA_WIDTH`, 32: address/PC width.
- `RESET_PC`, 0: first fetch address after reset; must be halfword aligned.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `redir`  in  1  redirect request; flush and restart at `redir_pc`.
- `redir_pc`  in  DATA_WIDTH  redirect target; bit 0 ignored, treated as 0.
- `m_req`  out  1  memory read request; held until acked.
- `m_addr`  out  DATA_WIDTH  word-aligned read address; bits [1:0] always 0.
- `m_ack`  in  1  read complete; `m_data` valid in the same cycle.
- `m_data`  in  32  read data; big-endian: [31:16] is at addr+0, [15:0] at addr+2.
- `d_ready`  in  1  decoder accepts a halfword this cycle.
- `opready`  out  1  queue head valid.
- `op`  out  16  head halfword.
- `pc_f`  out  DATA_WIDTH  address of `op`.
- `pcnext`  out  DATA_WIDTH  `pc_f + 2`, modulo 2^DATA_WIDTH.

## Operation
- Halfword queue: 4 entries, each holding `{op, addr}`; circular read/write pointers plus a 3-bit count (0..4).
- Pop: occurs at an edge where `opready & d_ready`.
- Push: occurs at an edge where `m_ack` is high and the response is not stale. It writes 2 entries, or 1 entry if the fetch started mid-word.
- `opready = (count != 0)`. `op`, `pc_f` and `pcnext` come combinationally from the head entry.
- Fetch pointer `fpc` is halfword-granular.
  - Request address is `{fpc[W-1:2], 2'b00}`.
  - If `fpc[1]` = 1, only `m_data[15:0]` is pushed, with addr `fpc`.
  - Otherwise both halves are pushed: addr `fpc`, then `fpc+2`.
  - After a push, `fpc <= {fpc[W-1:2],2'b00} + 4`.
- Issue rule: `m_req` rises at an edge where no request is outstanding and the free slots in the queue will be ≥2 after that edge's push and pop. At most one request is outstanding at a time.
- `m_req`/`m_addr` are registered. Once `m_req` is high, `m_addr` is stable until the ack edge.
  - If the issue rule still holds at the ack edge, `m_req` stays high with the next address (back-to-back).
  - Otherwise `m_req` drops at the ack edge.
- Redirect: at an edge where `redir` is high:
  - Count goes to 0, pointers reset, and any pop that edge is void.
  - `fpc <= redir_pc & ~1`.
  - If an ack arrives the same edge, its data is dropped.
  - If a request is pending without an ack, set `stale`. `m_req`/`m_addr` stay unchanged, and the next ack clears `stale` and is dropped.
  - A new request to the target is issued per the issue rule once nothing is outstanding. This is the same edge if nothing was pending.
- Simultaneous push and pop: count changes by (pushed − 1). A full queue never receives a push, guaranteed by the issue rule.
- Address arithmetic wraps modulo 2^DATA_WIDTH.

## Timing
- Reset values: `m_req`=0, `m_addr`=0, `opready`=0, queue storage 0 (so `op`=0, `pc_f`=0, `pcnext`=2), `fpc`=`RESET_PC`, `stale`=0, count 0.
- Reset is asynchronous. Asserting it mid-transaction abandons any outstanding read; the memory side must ignore acks for abandoned requests.
- First edge after reset release: `m_req`=1, `m_addr` = `RESET_PC` word address.
- Ack at edge N: `opready`=1 during cycle N+1 with the first halfword.
- Pipeline rates:
  - Zero-wait memory acking every cycle with `d_ready`=1 sustains 2 halfwords per request.
  - With one-cycle-ack memory, peak throughput is 2 halfwords/cycle in, 1 halfword/cycle out. The queue therefore fills, and requests throttle to 1 per 2 cycles.
- Redirect at edge N with no pending request: `m_req`=1 with the target in cycle N+1. First target op is visible the cycle after its ack.
- `opready` is 0 in the cycle after a redirect edge.

## Test plan
- Reset release, `RESET_PC`=0x100, memory acks 1 cycle after each request with 0x1234_5678:
  - op 0x1234 appears at `pc_f` 0x100 with `pcnext` 0x102.
  - Then op 0x5678 appears at `pc_f` 0x102.
  - The next request is at 0x104.
- `d_ready` held 0 and memory always acks:
  - count saturates at 4 and `m_req` stays 0.
  - Raising `d_ready` resumes requests once 2 slots free, with no halfword lost or duplicated.
- Redirect to 0x202 with queue empty:
  - `m_addr`=0x200; only `m_data[15:0]` is delivered, at `pc_f` 0x202.
  - The next request is at 0x204.
- Redirect to 0x400 while a request to 0x108 is pending:
  - the 0x108 ack data never reaches `op`.
  - The next `m_addr` is 0x400 and the first op has `pc_f` 0x400.
- Redirect coincident with `m_ack` and a pop:
  - queue empties and the acked data is dropped.
  - The 0x400 request is issued at that edge.
- Async reset asserted while `m_req`=1 with a full queue:
  - `m_req` and `opready` go to 0 immediately.
  - After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch unit: word reads from instruction memory, split into halfwords,
// buffered in a 4-entry queue and handed to the decoder with redirect/flush support.
module fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redir,
   input  logic [DATA_WIDTH-1:0] redir_pc,
   output logic                  m_req,
   output logic [DATA_WIDTH-1:0] m_addr,
   input  logic                  m_ack,
   input  logic [31:0]           m_data,
   input  logic                  d_ready,
   output logic                  opready,
   output logic [15:0]           op,
   output logic [DATA_WIDTH-1:0] pc_f,
   output logic [DATA_WIDTH-1:0] pcnext
);

   localparam logic [DATA_WIDTH-1:0] ADDR_TWO  = {{(DATA_WIDTH-3){1'b0}}, 3'd2};
   localparam logic [DATA_WIDTH-1:0] ADDR_FOUR = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

   logic [15:0]           q_op_r   [4];
   logic [DATA_WIDTH-1:0] q_addr_r [4];
   logic [1:0]            rd_ptr_r;
   logic [1:0]            wr_ptr_r;
   logic [2:0]            count_r;
   logic [DATA_WIDTH-1:0] fpc_r;
   logic                  m_req_r;
   logic [DATA_WIDTH-1:0] m_addr_r;
   logic                  stale_r;

   logic                  ack_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  half_s;
   logic                  busy_s;
   logic                  can_issue_s;
   logic [2:0]            push_cnt_s;
   logic [2:0]            count_nxt_s;
   logic [1:0]            wr_ptr1_s;
   logic [DATA_WIDTH-1:0] word_s;
   logic [DATA_WIDTH-1:0] fpc_nxt_s;
   logic                  req_nxt_s;
   logic [DATA_WIDTH-1:0] addr_nxt_s;
   logic                  stale_nxt_s;
   logic [15:0]           op0_s;

   // Handshake decode, queue bookkeeping and next request computation.
   always_comb begin
      ack_s       = m_ack & m_req_r;
      half_s      = fpc_r[1];
      // An ack is consumed but its data discarded when stale or racing a redirect.
      push_s      = ack_s & ~stale_r & ~redir;
      pop_s       = (count_r != 3'd0) & d_ready & ~redir;
      if (push_s) begin
         push_cnt_s = half_s ? 3'd1 : 3'd2;
      end else begin
         push_cnt_s = 3'd0;
      end
      if (redir) begin
         count_nxt_s = 3'd0;
      end else begin
         count_nxt_s = count_r + push_cnt_s - {2'b00, pop_s};
      end
      word_s = {fpc_r[DATA_WIDTH-1:2], 2'b00};
      if (redir) begin
         fpc_nxt_s = {redir_pc[DATA_WIDTH-1:1], 1'b0};
      end else if (push_s) begin
         fpc_nxt_s = word_s + ADDR_FOUR;
      end else begin
         fpc_nxt_s = fpc_r;
      end
      busy_s      = m_req_r & ~ack_s;
      can_issue_s = ~busy_s & (count_nxt_s <= 3'd2);
      stale_nxt_s = busy_s & (stale_r | redir);
      req_nxt_s   = busy_s | can_issue_s;
      if (can_issue_s) begin
         addr_nxt_s = {fpc_nxt_s[DATA_WIDTH-1:2], 2'b00};
      end else begin
         addr_nxt_s = m_addr_r;
      end
      op0_s     = half_s ? m_data[15:0] : m_data[31:16];
      wr_ptr1_s = wr_ptr_r + 2'd1;
   end

   // Fetch pointer, memory request and stale-response tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_r    <= RESET_PC;
         m_req_r  <= 1'b0;
         m_addr_r <= {DATA_WIDTH{1'b0}};
         stale_r  <= 1'b0;
      end else begin
         fpc_r    <= fpc_nxt_s;
         m_req_r  <= req_nxt_s;
         m_addr_r <= addr_nxt_s;
         stale_r  <= stale_nxt_s;
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_r <= 2'd0;
         wr_ptr_r <= 2'd0;
         count_r  <= 3'd0;
      end else if (redir) begin
         rd_ptr_r <= 2'd0;
         wr_ptr_r <= 2'd0;
         count_r  <= 3'd0;
      end else begin
         rd_ptr_r <= rd_ptr_r + {1'b0, pop_s};
         wr_ptr_r <= wr_ptr_r + push_cnt_s[1:0];
         count_r  <= count_nxt_s;
      end
   end

   // Queue storage: one entry for a mid-word fetch, otherwise both halves in order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            q_op_r[i]   <= 16'h0000;
            q_addr_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (push_s) begin
         q_op_r[wr_ptr_r]   <= op0_s;
         q_addr_r[wr_ptr_r] <= fpc_r;
         if (!half_s) begin
            q_op_r[wr_ptr1_s]   <= m_data[15:0];
            q_addr_r[wr_ptr1_s] <= fpc_r + ADDR_TWO;
         end
      end
   end

   assign m_req   = m_req_r;
   assign m_addr  = m_addr_r;
   assign opready = (count_r != 3'd0);
   assign op      = q_op_r[rd_ptr_r];
   assign pc_f    = q_addr_r[rd_ptr_r];
   assign pcnext  = q_addr_r[rd_ptr_r] + ADDR_TWO;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_fetch;
   localparam int          W   = 32;
   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] redir_pc = 32'h0;
   logic        m_ack = 1'b0;
   logic [31:0] m_data = 32'h0;
   logic        d_ready = 1'b0;
   logic        m_req;
   logic [31:0] m_addr;
   logic        opready;
   logic [15:0] op;
   logic [31:0] pc_f;
   logic [31:0] pcnext;

   fetch #(.DATA_WIDTH(W), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .redir(redir), .redir_pc(redir_pc),
      .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack), .m_data(m_data),
      .d_ready(d_ready), .opready(opready), .op(op), .pc_f(pc_f), .pcnext(pcnext)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] hw;
      logic [31:0] addr;
   } ent_t;

   ent_t        hq[$];
   logic [31:0] mf;
   logic        mreq;
   logic [31:0] maddr;
   logic        mstale;
   logic        fixed_data = 1'b0;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (fixed_data) return 32'h1234_5678;
      return {a[15:0] ^ 16'hC3A5, a[15:0] ^ a[31:16] ^ 16'h0F0F};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      mf     = RPC;
      mreq   = 1'b0;
      maddr  = 32'h0;
      mstale = 1'b0;
   endtask

   // Apply the rules of one clock edge to the model.
   task automatic model_edge();
      logic ack, pop, busy;
      ent_t e;
      ack  = m_ack;
      pop  = (hq.size() != 0) && d_ready && !redir;
      busy = mreq && !ack;
      if (pop) void'(hq.pop_front());
      if (ack) begin
         if (!mstale && !redir) begin
            if (mf[1]) begin
               e.hw = m_data[15:0]; e.addr = mf; hq.push_back(e);
            end else begin
               e.hw = m_data[31:16]; e.addr = mf; hq.push_back(e);
               e.hw = m_data[15:0]; e.addr = mf + 32'd2; hq.push_back(e);
            end
            mf = (mf & ~32'd3) + 32'd4;
         end
         mstale = 1'b0;
      end
      if (redir) begin
         hq.delete();
         mf = redir_pc & ~32'd1;
         if (busy) mstale = 1'b1;
      end
      if (!busy) begin
         if (hq.size() <= 2) begin
            mreq  = 1'b1;
            maddr = mf & ~32'd3;
         end else begin
            mreq = 1'b0;
         end
      end
   endtask

   task automatic compare();
      chk("m_req", 32'(m_req), 32'(mreq));
      if (mreq) chk("m_addr", m_addr, maddr);
      chk("opready", 32'(opready), 32'(hq.size() != 0));
      if (hq.size() != 0) begin
         chk("op", 32'(op), 32'(hq[0].hw));
         chk("pc_f", pc_f, hq[0].addr);
         chk("pcnext", pcnext, hq[0].addr + 32'd2);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare on the falling edge.
   task automatic step(input logic r, input logic [31:0] rpc, input logic a, input logic dr);
      redir    = r;
      redir_pc = rpc;
      m_ack    = a & mreq;
      d_ready  = dr;
      m_data   = mem(maddr);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      chk("rst_m_req", 32'(m_req), 32'd0);
      chk("rst_opready", 32'(opready), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      chk("reset_m_req", 32'(m_req), 32'd0);
      chk("reset_m_addr", m_addr, 32'h0);
      chk("reset_opready", 32'(opready), 32'd0);
      chk("reset_op", 32'(op), 32'h0);
      chk("reset_pc_f", pc_f, 32'h0);
      chk("reset_pcnext", pcnext, 32'h2);
      rst = 1'b1;

      // First fetch after reset with a fixed memory word.
      fixed_data = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("first_req", 32'(m_req), 32'd1);
      chk("first_addr", m_addr, 32'h100);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("first_op", 32'(op), 32'h1234);
      chk("first_pc_f", pc_f, 32'h100);
      chk("first_pcnext", pcnext, 32'h102);
      chk("next_addr", m_addr, 32'h104);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("second_op", 32'(op), 32'h5678);
      chk("second_pc_f", pc_f, 32'h102);
      fixed_data = 1'b0;

      // Decoder stalled, memory always acking: queue fills and requests stop.
      repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("sat_m_req", 32'(m_req), 32'd0);
      chk("sat_opready", 32'(opready), 32'd1);
      repeat (8) step(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'b1);

      // Reach a state with no outstanding request, then redirect mid-word.
      for (int k = 0; k < 10; k++) begin
         if (mreq) step(1'b0, 32'h0, 1'b1, 1'b0);
      end
      step(1'b1, 32'h203, 1'b0, 1'b0);
      chk("redir_req", 32'(m_req), 32'd1);
      chk("redir_addr", m_addr, 32'h200);
      chk("redir_opready", 32'(opready), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("half_pc_f", pc_f, 32'h202);
      chk("half_next_addr", m_addr, 32'h204);

      // Redirect while a request to 0x108 is outstanding.
      step(1'b1, 32'h108, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("pend_addr", m_addr, 32'h108);
      step(1'b1, 32'h400, 1'b0, 1'b1);
      chk("stale_addr_held", m_addr, 32'h108);
      chk("stale_opready", 32'(opready), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("after_stale_addr", m_addr, 32'h400);
      chk("after_stale_opready", 32'(opready), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("target_pc_f", pc_f, 32'h400);

      // Redirect coincident with an ack and a pop.
      step(1'b1, 32'h400, 1'b1, 1'b1);
      chk("coinc_opready", 32'(opready), 32'd0);
      chk("coinc_req", 32'(m_req), 32'd1);
      chk("coinc_addr", m_addr, 32'h400);

      // Async reset with a request outstanding and data queued.
      step(1'b0, 32'h0, 1'b1, 1'b0);
      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("restart_addr", m_addr, 32'h100);

      // Randomized traffic, ending with a zero-wait streaming phase.
      for (int i = 0; i < 4000; i++) begin
         logic r, a, dr;
         logic [31:0] rpc;
         dr  = ($urandom_range(0, 9) < 7);
         a   = ($urandom_range(0, 9) < 6);
         r   = ($urandom_range(0, 39) == 0);
         rpc = $urandom;
         if (i >= 3200) begin
            a = 1'b1; dr = 1'b1; r = 1'b0;
         end
         if (i == 1500) do_reset();
         step(r, rpc, a, dr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
